// File: rtl/complement_arbiter.sv
// ---------------------------------------------------------------------------
// complement_arbiter
//
// Two requesters share one two's-complement unit that computes either the
// negation or the absolute value of a WIDTH-bit operand. Requests are granted
// round-robin. Each request is carried through a short IDLE -> EXEC -> RESP
// sequence. The result comes back on one response channel, tagged with the
// id of the requester that issued it.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous, active-low reset
//   req0_valid     requester 0 has a request
//   req0_ready     requester 0 request accepted this cycle
//   req0_operand   requester 0 operand (WIDTH bits)
//   req0_abs       requester 0 op select: 0 = negate, 1 = absolute value
//   req1_valid     requester 1 has a request
//   req1_ready     requester 1 request accepted this cycle
//   req1_operand   requester 1 operand (WIDTH bits)
//   req1_abs       requester 1 op select: 0 = negate, 1 = absolute value
//   resp_valid     response available
//   resp_ready     consumer takes the response
//   resp_data      result (WIDTH bits)
//   resp_id        requester that issued this result
//   resp_ovf       result not representable (operand was the most-negative value)
//   busy           high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module complement_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_operand,
    input  logic             req0_abs,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_operand,
    input  logic             req1_abs,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             resp_ovf,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // The only operand whose negation wraps back onto itself.
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic             rr_last;

    // The operation captured at accept time. It is consumed in EXEC.
    logic [WIDTH-1:0] op_operand;
    logic             op_abs;
    logic             op_id;

    logic             grant0;
    logic             grant1;

    logic [WIDTH-1:0] negated;
    logic [WIDTH-1:0] result;
    logic             overflow;

    // Round-robin grant selection. A lone requester always wins. When both
    // requesters ask at once, the one that was not served last time wins.
    // rr_last resets to 1, so the first contested grant after reset goes to
    // requester 0.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = rr_last;
            grant1 = ~rr_last;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // A grant only turns into a ready while the FSM is idle. Gating with
    // rst_n keeps both readies low for the whole reset assertion, even though
    // the state register already reads IDLE during reset.
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;

    // The shared complement datapath works on the captured operand.
    // Absolute value passes non-negative operands through unchanged and
    // negates negative ones. The most-negative value negates to itself.
    // It is flagged as overflow for both operations.
    always_comb begin
        negated  = ~op_operand + ONE;
        result   = (op_abs && !op_operand[WIDTH-1]) ? op_operand : negated;
        overflow = (op_operand == MOST_NEG);
    end

    // Main controller. IDLE accepts one request and latches it. EXEC spends
    // exactly one cycle registering the result into the response outputs.
    // RESP holds those outputs until the consumer takes them. busy is
    // registered together with the state, so it always matches state != IDLE.
    // Reset throws away any operation in flight, so no response for it can
    // appear afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_last    <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            resp_ovf   <= 1'b0;
            op_operand <= '0;
            op_abs     <= 1'b0;
            op_id      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_operand <= grant1 ? req1_operand : req0_operand;
                        op_abs     <= grant1 ? req1_abs : req0_abs;
                        op_id      <= grant1;
                        rr_last    <= grant1;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data  <= result;
                    resp_ovf   <= overflow;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complement_arbiter.sv
// ---------------------------------------------------------------------------
// tb_complement_arbiter
//
// Self-checking bench for complement_arbiter. A cycle monitor compares every
// cycle against a transaction-level reference. That reference tracks whether
// an operation is in flight and how many cycles have passed since it was
// accepted. It computes results with plain signed arithmetic. The directed
// scenario tasks also make their own targeted comparisons against constants.
// ---------------------------------------------------------------------------
module tb_complement_arbiter;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_operand;
    logic         req0_abs;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_operand;
    logic         req1_abs;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_id;
    logic         resp_ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    complement_arbiter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_operand (req0_operand),
        .req0_abs     (req0_abs),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_operand (req1_operand),
        .req1_abs     (req1_abs),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_id      (resp_id),
        .resp_ovf     (resp_ovf),
        .busy         (busy)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Cycle index. Cycle-based reasoning uses it, e.g. accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic. Negation is 0 - x modulo 2^W. Absolute value
    // negates only operands that are negative when read as signed.
    function automatic logic [W-1:0] ref_data(input logic [W-1:0] x, input logic is_abs);
        logic signed [W-1:0] sx;
        logic [W-1:0]        zero;
        sx   = x;
        zero = '0;
        if (is_abs && sx >= 0) return x;
        return zero - x;
    endfunction

    // Random operands, with the interesting edge values mixed in often.
    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return MIN_VAL;
            1:       return '0;
            2:       return '1;
            3:       return MIN_VAL - 1;
            default: return $urandom;
        endcase
    endfunction

    // Reference model state. Only transaction-level facts are kept:
    // whether an op is in flight, cycles since its accept, the expected
    // response, and who was served last.
    bit           m_inflight = 1'b0;
    int           m_phase    = 0;
    bit           m_rr_last  = 1'b1;
    logic [W-1:0] m_data;
    bit           m_id;
    bit           m_ovf;

    // Per-cycle monitor. It runs on the falling edge, away from the active
    // clock edge, and compares every DUT output against the reference.
    always @(negedge clk) begin : monitor
        logic         e0;
        logic         e1;
        logic [W-1:0] x;
        logic         a;
        if (!rst_n) begin
            m_inflight = 1'b0;
            m_rr_last  = 1'b1;
            checks++;
            if ({req0_ready, req1_ready, resp_valid, busy} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL mon_reset_ctrl: got r0/r1/rv/busy=%b expected 0000",
                         {req0_ready, req1_ready, resp_valid, busy});
            end
            checks++;
            if ({resp_data, resp_id, resp_ovf} !== '0) begin
                errors++;
                $display("[TB] FAIL mon_reset_resp: got data=%h id=%b ovf=%b expected all zero",
                         resp_data, resp_id, resp_ovf);
            end
        end else if (!m_inflight) begin
            if (req0_valid && req1_valid) begin
                e0 = m_rr_last;
                e1 = ~m_rr_last;
            end else begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
            checks++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                errors++;
                $display("[TB] FAIL mon_grant @%0d: got ready0/1=%b%b expected %b%b",
                         cyc, req0_ready, req1_ready, e0, e1);
            end
            checks++;
            if ({busy, resp_valid} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL mon_idle @%0d: got busy/rv=%b%b expected 00",
                         cyc, busy, resp_valid);
            end
            if (e0 || e1) begin
                x          = e1 ? req1_operand : req0_operand;
                a          = e1 ? req1_abs : req0_abs;
                m_id       = e1;
                m_data     = ref_data(x, a);
                m_ovf      = (x == MIN_VAL);
                m_rr_last  = e1;
                m_inflight = 1'b1;
                m_phase    = 0;
            end
        end else begin
            m_phase++;
            checks++;
            if ({req0_ready, req1_ready, busy} !== 3'b001) begin
                errors++;
                $display("[TB] FAIL mon_busy @%0d: got r0/r1/busy=%b expected 001",
                         cyc, {req0_ready, req1_ready, busy});
            end
            if (m_phase == 1) begin
                checks++;
                if (resp_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mon_exec_rv @%0d: got resp_valid=%b expected 0", cyc, resp_valid);
                end
            end else begin
                checks++;
                if (resp_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL mon_resp_rv @%0d: got resp_valid=%b expected 1", cyc, resp_valid);
                end
                checks++;
                if ({resp_data, resp_id, resp_ovf} !== {m_data, m_id, m_ovf}) begin
                    errors++;
                    $display("[TB] FAIL mon_resp @%0d: got data=%h id=%b ovf=%b expected data=%h id=%b ovf=%b",
                             cyc, resp_data, resp_id, resp_ovf, m_data, m_id, m_ovf);
                end
                if (resp_ready) m_inflight = 1'b0;
            end
        end
    end

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req0_valid   = 1'b1;
        req1_valid   = 1'b1;
        req0_operand = 32'h0000_0005;
        req1_operand = 32'h0000_0007;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        checks++;
        if ({resp_valid, busy, resp_id, resp_ovf} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got rv/busy/id/ovf=%b expected 0000",
                     {resp_valid, busy, resp_id, resp_ovf});
        end
        checks++;
        if (resp_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", resp_data);
        end
        tick();
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, resp_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_release: got busy/rv=%b%b expected 00", busy, resp_valid);
        end
        tick();
    endtask

    task automatic test_single_neg();
        req0_operand = 32'h0000_0005;
        req0_abs     = 1'b0;
        req0_valid   = 1'b1;
        resp_ready   = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL neg5_accept: got ready0=%b expected 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL neg5_early: got resp_valid=%b expected 0", resp_valid);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL neg5_latency: got resp_valid=%b expected 1", resp_valid);
        end
        checks++;
        if ({resp_data, resp_id, resp_ovf} !== {32'hFFFF_FFFB, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL neg5_data: got data=%h id=%b ovf=%b expected FFFFFFFB 0 0",
                     resp_data, resp_id, resp_ovf);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL neg5_idle: got busy=%b expected 0", busy);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int acc_cyc[$];
        bit acc_id[$];
        bit a0;
        bit a1;
        do_reset();
        resp_ready   = 1'b1;
        req0_operand = $urandom;
        req1_operand = $urandom;
        req0_abs     = 1'($urandom_range(0, 1));
        req1_abs     = 1'($urandom_range(0, 1));
        req0_valid   = 1'b1;
        req1_valid   = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b0); end
            if (a1) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b1); end
            tick();
            if (a0) req0_operand = $urandom;
            if (a1) req1_operand = $urandom;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (acc_id.size() != 5) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d accepts expected 5", acc_id.size());
        end
        for (int k = 0; k < acc_id.size(); k++) begin
            checks++;
            if (acc_id[k] !== k[0]) begin
                errors++;
                $display("[TB] FAIL rr_order%0d: got id=%b expected %b", k, acc_id[k], k[0]);
            end
            if (k > 0) begin
                checks++;
                if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
                    errors++;
                    $display("[TB] FAIL rr_spacing%0d: got %0d cycles expected 3",
                             k, acc_cyc[k] - acc_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] vin  [7] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'h0000_0000,
                                   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        bit           vabs [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] vexp [7] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0010, 32'h0000_0000,
                                   32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
        bit           vovf [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit got;
        bit rid;
        resp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rid = i[0];
            if (rid) begin
                req1_operand = vin[i]; req1_abs = vabs[i]; req1_valid = 1'b1;
            end else begin
                req0_operand = vin[i]; req0_abs = vabs[i]; req0_valid = 1'b1;
            end
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                got = rid ? req1_ready : req0_ready;
                if (!got) tick();
            end
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL bnd_accept%0d: got no ready within 10 cycles expected accept", i);
            end
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                got = resp_valid;
                if (!got) tick();
            end
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL bnd_resp%0d: got no resp_valid within 10 cycles expected response", i);
            end
            checks++;
            if ({resp_data, resp_ovf, resp_id} !== {vexp[i], vovf[i], rid}) begin
                errors++;
                $display("[TB] FAIL bnd_vec%0d: got data=%h ovf=%b id=%b expected data=%h ovf=%b id=%b",
                         i, resp_data, resp_ovf, resp_id, vexp[i], vovf[i], rid);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit           got;
        logic [W-1:0] d;
        logic         id;
        logic         o;
        logic [W-1:0] op1;
        resp_ready   = 1'b0;
        req0_operand = rand_operand();
        req0_abs     = 1'b1;
        req0_valid   = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            got = req0_ready;
            if (!got) tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL bp_accept: got no ready0 within 10 cycles expected accept");
        end
        tick();
        req0_valid   = 1'b0;
        op1          = rand_operand();
        req1_operand = op1;
        req1_abs     = 1'b0;
        req1_valid   = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            got = resp_valid;
            if (!got) tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL bp_resp: got no resp_valid within 10 cycles expected response");
        end
        d  = resp_data;
        id = resp_id;
        o  = resp_ovf;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({resp_valid, resp_data, resp_id, resp_ovf} !== {1'b1, d, id, o}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got rv=%b data=%h id=%b ovf=%b expected rv=1 data=%h id=%b ovf=%b",
                         k, resp_valid, resp_data, resp_id, resp_ovf, d, id, o);
            end
            checks++;
            if ({busy, req0_ready, req1_ready} !== 3'b100) begin
                errors++;
                $display("[TB] FAIL bp_stall%0d: got busy/r0/r1=%b expected 100",
                         k, {busy, req0_ready, req1_ready});
            end
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: got resp_valid=%b expected 1", resp_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_idle: got busy=%b expected 0", busy);
        end
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_waiting_req1: got ready1=%b expected 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            got = resp_valid;
            if (!got) tick();
        end
        checks++;
        if ({got, resp_id, resp_data} !== {1'b1, 1'b1, ref_data(op1, 1'b0)}) begin
            errors++;
            $display("[TB] FAIL bp_req1_resp: got seen=%b id=%b data=%h expected seen=1 id=1 data=%h",
                     got, resp_id, resp_data, ref_data(op1, 1'b0));
        end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        bit got;
        resp_ready   = 1'b1;
        req0_operand = rand_operand();
        req0_abs     = 1'b0;
        req0_valid   = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_accept: got ready0=%b expected 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, resp_valid, busy, resp_id, resp_ovf} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_flags: got r0/r1/rv/busy/id/ovf=%b expected 000000",
                     {req0_ready, req1_ready, resp_valid, busy, resp_id, resp_ovf});
        end
        checks++;
        if (resp_data !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid_data: got %h expected 0", resp_data);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rst_mid_stale%0d: got resp_valid=%b expected 0", k, resp_valid);
            end
            tick();
        end
        req1_operand = 32'h0000_0001;
        req1_abs     = 1'b0;
        req1_valid   = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            got = req1_ready;
            if (!got) tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL rst_mid_next_accept: got no ready1 within 10 cycles expected accept");
        end
        tick();
        req1_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            got = resp_valid;
            if (!got) tick();
        end
        checks++;
        if ({got, resp_data, resp_id, resp_ovf} !== {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rst_mid_next_resp: got seen=%b data=%h id=%b ovf=%b expected 1 FFFFFFFF 1 0",
                     got, resp_data, resp_id, resp_ovf);
        end
        tick();
    endtask

    task automatic test_random();
        bit a0;
        bit a1;
        bit idle;
        int accepts = 0;
        int resps   = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0 || a1) accepts++;
            if (resp_valid && resp_ready) resps++;
            tick();
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_operand = rand_operand();
                req0_abs     = 1'($urandom_range(0, 1));
                req0_valid   = 1'b1;
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_operand = rand_operand();
                req1_abs     = 1'($urandom_range(0, 1));
                req1_valid   = 1'b1;
            end
            resp_ready = ($urandom_range(0, 9) < 7);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        idle = 1'b0;
        for (int t = 0; t < 10 && !idle; t++) begin
            @(negedge clk);
            if (resp_valid && resp_ready) resps++;
            idle = !busy && !resp_valid;
            if (!idle) tick();
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("[TB] FAIL rand_drain: got busy=%b after 10 cycles expected idle", busy);
        end
        checks++;
        if (accepts != resps || accepts < 40) begin
            errors++;
            $display("[TB] FAIL rand_balance: got accepts=%0d responses=%0d expected equal and >= 40",
                     accepts, resps);
        end
        tick();
    endtask

    // Hard time limit, so the run can never hang on a broken design.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got no completion by 200000 ns expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        rst_n        = 1'b1;
        req0_valid   = 1'b0;
        req0_operand = '0;
        req0_abs     = 1'b0;
        req1_valid   = 1'b0;
        req1_operand = '0;
        req1_abs     = 1'b0;
        resp_ready   = 1'b0;
        test_reset();
        test_single_neg();
        test_round_robin();
        test_boundaries();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
